// File: rtl/imem_loader.sv
// Byte-stream program loader that packs 32-bit instructions into 64-bit imem rows.
// Optional trailing checksum byte check with IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int ROWS  = 64,
  parameter int ROW_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       num_instr,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             wr_en,
  output logic [ROW_W-1:0] wr_row,
  output logic [63:0]      wr_data,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam logic [8:0] CAP = 9'(2 * ROWS);

`ifdef IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, LOAD, CHECK} state_t;
  logic [7:0] sum_q, sum_d;
  logic       err_d;
`else
  typedef enum logic [1:0] {IDLE, LOAD} state_t;
`endif

  state_t state_q, state_d;

  logic [7:0]       n_q, n_d, n_sat;
  logic [7:0]       icnt_q, icnt_d;
  logic [1:0]       bcnt_q, bcnt_d;
  logic [23:0]      cur_q, cur_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      instr;
  logic             accept, last;
  logic             rdy_d, busy_d, wr_en_d, done_d;
  logic [ROW_W-1:0] wr_row_d;
  logic [63:0]      wr_data_d;

  assign n_sat  = ({1'b0, num_instr} > CAP) ? CAP[7:0] : num_instr;
  assign accept = in_valid & in_ready;
  assign instr  = {in_data, cur_q};
  assign last   = (icnt_q == n_q - 8'd1);

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    icnt_d    = icnt_q;
    bcnt_d    = bcnt_q;
    cur_d     = cur_q;
    lo_d      = lo_q;
    rdy_d     = in_ready;
    busy_d    = busy;
    wr_en_d   = 1'b0;
    wr_row_d  = wr_row;
    wr_data_d = wr_data;
    done_d    = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d     = sum_q;
    err_d     = err;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          n_d    = n_sat;
          icnt_d = '0;
          bcnt_d = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d  = '0;
          err_d  = 1'b0;
`endif
          if (n_sat == 8'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = CHECK;
            rdy_d   = 1'b1;
            busy_d  = 1'b1;
`else
            done_d  = 1'b1;
`endif
          end else begin
            state_d = LOAD;
            rdy_d   = 1'b1;
            busy_d  = 1'b1;
          end
        end
      end
      LOAD: begin
        if (accept) begin
          bcnt_d = bcnt_q + 2'd1;
          cur_d  = {in_data, cur_q[23:8]};
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d  = sum_q + in_data;
`endif
          if (bcnt_q == 2'd3) begin
            icnt_d = icnt_q + 8'd1;
            if (!icnt_q[0]) lo_d = instr;
            if (icnt_q[0] || last) begin
              wr_en_d   = 1'b1;
              wr_row_d  = ROW_W'(icnt_q >> 1);
              wr_data_d = icnt_q[0] ? {instr, lo_q}
                                    : {32'h0, instr};
            end
            if (last) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_d = CHECK;
`else
              state_d = IDLE;
              rdy_d   = 1'b0;
              busy_d  = 1'b0;
              done_d  = 1'b1;
`endif
            end
          end
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        if (accept) begin
          err_d   = ((sum_q + in_data) != 8'd0);
          state_d = IDLE;
          rdy_d   = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      n_q      <= '0;
      icnt_q   <= '0;
      bcnt_q   <= '0;
      cur_q    <= '0;
      lo_q     <= '0;
      in_ready <= 1'b0;
      busy     <= 1'b0;
      wr_en    <= 1'b0;
      wr_row   <= '0;
      wr_data  <= '0;
      done     <= 1'b0;
    end else begin
      state_q  <= state_d;
      n_q      <= n_d;
      icnt_q   <= icnt_d;
      bcnt_q   <= bcnt_d;
      cur_q    <= cur_d;
      lo_q     <= lo_d;
      in_ready <= rdy_d;
      busy     <= busy_d;
      wr_en    <= wr_en_d;
      wr_row   <= wr_row_d;
      wr_data  <= wr_data_d;
      done     <= done_d;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      err   <= 1'b0;
    end else begin
      sum_q <= sum_d;
      err   <= err_d;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table-driven loads plus reset,
// saturation and empty-load sequences.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  num_instr = '0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic        in_ready, wr_en, busy, done, err;
  logic [5:0]  wr_row;
  logic [63:0] wr_data;

  imem_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .num_instr(num_instr), .in_valid(in_valid),
    .in_data(in_data), .in_ready(in_ready),
    .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  logic [5:0]  mrow[256];
  logic [63:0] mdata[256];
  int          wr_cnt = 0;
  int          done_cnt = 0;
  logic        done_wr = 1'b0;
  logic        done_err = 1'b0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        mrow[wr_cnt & 255] = wr_row;
        mdata[wr_cnt & 255] = wr_data;
        wr_cnt++;
      end
      if (done) begin
        done_cnt++;
        done_wr = wr_en && !busy;
        done_err = err;
      end
    end
  end

  logic [31:0] words[128];
  logic        st_busy, st_rdy;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input int gap, input bit pokes);
    int t;
    for (int g = 0; g < gap; g++) begin
      @(negedge clk);
      in_valid = 1'b0;
      start = pokes ? 1'($urandom_range(0, 1)) : 1'b0;
      num_instr = 8'd1;
    end
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    in_data = b;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("send_timeout", 64'(t), 64'(0));
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    in_valid = 1'b0;
    start = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic run_load(input logic [7:0] nreq, input int nsend,
                          input bit gaps, input bit pokes,
                          input logic [7:0] bias);
    logic [7:0] s;
    logic [7:0] b;
    s = 8'd0;
    @(negedge clk);
    start = 1'b1;
    num_instr = nreq;
    @(negedge clk);
    start = 1'b0;
    st_busy = busy;
    st_rdy = in_ready;
    for (int i = 0; i < nsend; i++) begin
      for (int k = 0; k < 4; k++) begin
        b = words[i][8*k +: 8];
        s = s + b;
        send(b, gaps ? int'($urandom_range(0, 2)) : 0, pokes);
      end
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send(8'(8'd0 - s) + bias, 0, 1'b0);
`endif
    idle(3);
  endtask

  typedef struct {
    logic [7:0]       n;
    logic [3:0][31:0] w;
    bit               gaps;
    bit               pokes;
    int               nwr;
    logic [5:0]       r0;
    logic [63:0]      d0;
    logic [5:0]       rl;
    logic [63:0]      dl;
  } vec_t;

  vec_t tv[5];

  initial begin
    int bw, bd, li, bad;
    tv[0] = '{8'd2, {32'h0, 32'h0, 32'h00100093, 32'h00000013},
              1'b0, 1'b0, 1, 6'd0, 64'h00100093_00000013,
              6'd0, 64'h00100093_00000013};
    tv[1] = '{8'd3, {32'h0, 32'h00208133, 32'h00100093, 32'h00000013},
              1'b0, 1'b0, 2, 6'd0, 64'h00100093_00000013,
              6'd1, 64'h00000000_00208133};
    tv[2] = '{8'd1, {32'h0, 32'h0, 32'h0, 32'hDEADBEEF},
              1'b0, 1'b0, 1, 6'd0, 64'h00000000_DEADBEEF,
              6'd0, 64'h00000000_DEADBEEF};
    tv[3] = '{8'd4, {32'hDDEEFF00, 32'h99AABBCC, 32'h55667788, 32'h11223344},
              1'b0, 1'b0, 2, 6'd0, 64'h55667788_11223344,
              6'd1, 64'hDDEEFF00_99AABBCC};
    tv[4] = '{8'd3, {32'h0, 32'h00208133, 32'h00100093, 32'h00000013},
              1'b1, 1'b1, 2, 6'd0, 64'h00100093_00000013,
              6'd1, 64'h00000000_00208133};

    #12;
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_wr_en", 64'(wr_en), 64'(0));
    chk("rst_wr_row", 64'(wr_row), 64'(0));
    chk("rst_wr_data", wr_data, 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_err", 64'(err), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    for (int v = 0; v < 5; v++) begin
      for (int i = 0; i < 4; i++) words[i] = tv[v].w[i];
      bw = wr_cnt;
      bd = done_cnt;
      run_load(tv[v].n, int'(tv[v].n), tv[v].gaps, tv[v].pokes, 8'd0);
      li = (bw + tv[v].nwr - 1) & 255;
      chk($sformatf("v%0d_start_busy", v), 64'(st_busy), 64'(1));
      chk($sformatf("v%0d_start_rdy", v), 64'(st_rdy), 64'(1));
      chk($sformatf("v%0d_nwr", v), 64'(wr_cnt - bw), 64'(tv[v].nwr));
      chk($sformatf("v%0d_row0", v), 64'(mrow[bw & 255]), 64'(tv[v].r0));
      chk($sformatf("v%0d_data0", v), mdata[bw & 255], tv[v].d0);
      chk($sformatf("v%0d_rowl", v), 64'(mrow[li]), 64'(tv[v].rl));
      chk($sformatf("v%0d_datal", v), mdata[li], tv[v].dl);
      chk($sformatf("v%0d_ndone", v), 64'(done_cnt - bd), 64'(1));
`ifdef IMEM_LOADER_CHECKSUM_EN
      chk($sformatf("v%0d_err", v), 64'(done_err), 64'(0));
`else
      chk($sformatf("v%0d_done_wr", v), 64'(done_wr), 64'(1));
`endif
      chk($sformatf("v%0d_idle_busy", v), 64'(busy), 64'(0));
    end

    // empty load
    bw = wr_cnt;
    bd = done_cnt;
    @(negedge clk);
    start = 1'b1;
    num_instr = 8'd0;
    @(negedge clk);
    start = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
    chk("n0_busy", 64'(busy), 64'(1));
    send(8'h00, 0, 1'b0);
    idle(3);
    chk("n0_err", 64'(done_err), 64'(0));
`else
    chk("n0_done", 64'(done), 64'(1));
    chk("n0_busy", 64'(busy), 64'(0));
    idle(3);
`endif
    chk("n0_nwr", 64'(wr_cnt - bw), 64'(0));
    chk("n0_ndone", 64'(done_cnt - bd), 64'(1));

    // reset after 6 bytes of a 4-instruction load
    words[0] = 32'h11111111;
    words[1] = 32'h22222222;
    @(negedge clk);
    start = 1'b1;
    num_instr = 8'd4;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 6; k++) send(8'(8'h30 + k), 0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 64'(busy), 64'(0));
    chk("mid_rst_rdy", 64'(in_ready), 64'(0));
    chk("mid_rst_row", 64'(wr_row), 64'(0));
    chk("mid_rst_data", wr_data, 64'(0));
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    bw = wr_cnt;
    words[0] = 32'hAAAA0001;
    words[1] = 32'hBBBB0002;
    run_load(8'd2, 2, 1'b0, 1'b0, 8'd0);
    chk("post_rst_nwr", 64'(wr_cnt - bw), 64'(1));
    chk("post_rst_row", 64'(mrow[bw & 255]), 64'(0));
    chk("post_rst_data", mdata[bw & 255], 64'hBBBB0002_AAAA0001);

    // reset while the row strobe is high
    @(negedge clk);
    start = 1'b1;
    num_instr = 8'd2;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 2; i++)
      for (int k = 0; k < 4; k++) send(words[i][8*k +: 8], 0, 1'b0);
    #2;
    chk("wr_pre_rst", 64'(wr_en), 64'(1));
    rst_n = 1'b0;
    #1;
    chk("wr_async_rst", 64'(wr_en), 64'(0));
    chk("done_async_rst", 64'(done), 64'(0));
    in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;

    // oversize count saturates to the full memory
    for (int i = 0; i < 128; i++)
      words[i] = {8'hA5, 16'(i), 8'(i * 3)};
    bw = wr_cnt;
    bd = done_cnt;
    run_load(8'd200, 128, 1'b0, 1'b0, 8'd0);
    chk("sat_nwr", 64'(wr_cnt - bw), 64'(64));
    bad = 0;
    for (int r = 0; r < 64; r++) begin
      if (mrow[(bw + r) & 255] !== 6'(r)) bad++;
      if (mdata[(bw + r) & 255] !== {words[2*r+1], words[2*r]}) bad++;
    end
    chk("sat_rows", 64'(bad), 64'(0));
    chk("sat_ndone", 64'(done_cnt - bd), 64'(1));
    chk("sat_idle_rdy", 64'(in_ready), 64'(0));

`ifdef IMEM_LOADER_CHECKSUM_EN
    words[0] = 32'h00000013;
    bw = wr_cnt;
    run_load(8'd1, 1, 1'b0, 1'b0, 8'd0);
    chk("cs_good_err", 64'(done_err), 64'(0));
    run_load(8'd1, 1, 1'b0, 1'b0, 8'd1);
    chk("cs_bad_err", 64'(done_err), 64'(1));
    chk("cs_bad_held", 64'(err), 64'(1));
    chk("cs_bad_row", mdata[(bw + 1) & 255], 64'h00000000_00000013);
    run_load(8'd1, 1, 1'b0, 1'b0, 8'd0);
    chk("cs_clear_err", 64'(err), 64'(0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

endmodule
